// File: rtl/mips_timer_pkg.sv
// Shared definitions for the mips_timer countdown timer: register map, CTRL bit
// positions, mode encodings and the FSM state type.
package mips_timer_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_PEND    = 4;

    // Modes 2 and 3 are not decoded and therefore behave as one-shot.
    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_AUTO    = 2'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } timerState_t;

endpackage

// File: rtl/mips_timer_prescaler.sv
// Free-running prescaler for mips_timer; only built with TIMER_PRESCALE_EN, where
// tick marks the cycles in which the main count is allowed to advance.
`ifdef TIMER_PRESCALE_EN
module timer_prescaler #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    logic [WIDTH-1:0] psCount;

    always_ff @(posedge clk) begin
        if (reset)
            psCount <= '0;
        else if (clear)
            psCount <= '0;
        else if (enable)
            psCount <= psCount + WIDTH'(1);
    end

    assign tick = &psCount;

endmodule
`endif

// File: rtl/mips_timer.sv
// Memory-mapped countdown timer driving one CP0 interrupt line; the optional
// prescaler is enabled with the TIMER_PRESCALE_EN macro.
module mips_timer
    import mips_timer_pkg::*;
#(
    parameter int PRESCALE_LOG2 = 4
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    timerState_t state, nextState;
    logic        en, im, pending;
    logic [1:0]  mode;
    logic [31:0] preset, count;
    logic        ctrlWrite, presetWrite;
    logic        loadCount, decCount, expire, hwClrEn, hwClrPend;
    logic        tick;

    assign ctrlWrite   = we && (addr == ADDR_CTRL);
    assign presetWrite = we && (addr == ADDR_PRESET);

`ifdef TIMER_PRESCALE_EN
    timer_prescaler #(.WIDTH(PRESCALE_LOG2)) uPrescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (loadCount),
        .enable (state == CNT),
        .tick   (tick)
    );
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        loadCount = 1'b0;
        decCount  = 1'b0;
        expire    = 1'b0;
        hwClrEn   = 1'b0;
        hwClrPend = 1'b0;
        case (state)
            IDLE: if (en) nextState = LOAD;
            LOAD: begin
                loadCount = 1'b1;
                nextState = CNT;
            end
            CNT: begin
                if (!en)
                    nextState = IDLE;
                else if (tick) begin
                    if (count > 32'd1)
                        decCount = 1'b1;
                    else begin
                        expire    = 1'b1;
                        nextState = INT;
                    end
                end
            end
            INT: begin
                // Auto-reload drops pending after one cycle so irq is a pulse.
                if (mode == MODE_AUTO) begin
                    hwClrPend = 1'b1;
                    nextState = en ? LOAD : IDLE;
                end else begin
                    hwClrEn   = 1'b1;
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // A CTRL write always overrides same-cycle hardware updates of EN and pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            en      <= 1'b0;
            mode    <= MODE_ONESHOT;
            im      <= 1'b0;
            pending <= 1'b0;
            preset  <= '0;
            count   <= '0;
        end else begin
            if (loadCount)
                count <= preset;
            else if (decCount)
                count <= count - 32'd1;
            else if (expire)
                count <= '0;

            if (ctrlWrite) begin
                en      <= wdata[CTRL_EN];
                mode    <= wdata[CTRL_MODE_HI:CTRL_MODE_LO];
                im      <= wdata[CTRL_IM];
                pending <= 1'b0;
            end else begin
                if (hwClrEn)
                    en <= 1'b0;
                if (expire)
                    pending <= 1'b1;
                else if (hwClrPend)
                    pending <= 1'b0;
            end

            if (presetWrite)
                preset <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_CTRL: begin
                rdata[CTRL_EN]                   = en;
                rdata[CTRL_MODE_HI:CTRL_MODE_LO] = mode;
                rdata[CTRL_IM]                   = im;
                rdata[CTRL_PEND]                 = pending;
            end
            ADDR_PRESET: rdata = preset;
            ADDR_COUNT:  rdata = count;
            default:     rdata = '0;
        endcase
    end

    assign irq = im & pending;

endmodule

// File: tb/tb_mips_timer.sv
// Directed and randomized bench for mips_timer; expected irq timing comes from the
// closed-form expiry delay and reload period rather than a cycle model.
module tb_mips_timer;
    import mips_timer_pkg::*;

`ifdef TIMER_PRESCALE_EN
    localparam int PS = 4;
`else
    localparam int PS = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    mips_timer #(.PRESCALE_LOG2(2)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One register write; returns 1 time unit after the edge that captured it.
    task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkReg(input string tag, input logic [1:0] a, input logic [31:0] expected);
        addr = a;
        #1;
        checkOutput(tag, rdata, expected);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic int expiryDelay(input int p);
        return ((p < 1) ? 1 : p) * PS + 2;
    endfunction

    // irq expected k edges after the enabling CTRL write.
    function automatic logic irqExpected(input int k, input int p, input logic autoMode, input logic imBit);
        int d;
        d = expiryDelay(p);
        if (!imBit || k < d)
            return 1'b0;
        if (autoMode)
            return ((k - d) % d) == 0;
        return 1'b1;
    endfunction

    task automatic runIrqWindow(input string tag, input int p, input logic autoMode,
                                input logic imBit, input int n, output int pulses);
        pulses = 0;
        for (int k = 1; k <= n; k++) begin
            waitEdges(1);
            if (irq === 1'b1)
                pulses++;
            checkOutput(tag, {31'd0, irq}, {31'd0, irqExpected(k, p, autoMode, imBit)});
        end
    endtask

    task automatic stopTimer(input string tag);
        applyStimulus(ADDR_CTRL, 32'h0);
        waitEdges(4);
        checkOutput(tag, {31'd0, irq}, 32'd0);
        checkReg(tag, ADDR_CTRL, 32'h0);
    endtask

    initial begin
        int pulses;
        int p, d, hold;
        logic [1:0] md;
        logic imBit;

        // Reset state and read-only/reserved locations
        waitEdges(2);
        pulseReset();
        checkReg("rstCtrl", ADDR_CTRL, 32'h0);
        checkReg("rstPreset", ADDR_PRESET, 32'h0);
        checkReg("rstCount", ADDR_COUNT, 32'h0);
        checkReg("rstRsvd", 2'd3, 32'h0);
        checkOutput("rstIrq", {31'd0, irq}, 32'd0);
        applyStimulus(ADDR_COUNT, 32'h1234);
        checkReg("countRO", ADDR_COUNT, 32'h0);
        applyStimulus(2'd3, 32'hDEAD_BEEF);
        checkReg("rsvdRO", 2'd3, 32'h0);

        // One-shot, PRESET=5, IM set
        applyStimulus(ADDR_PRESET, 32'd5);
        checkReg("presetRW", ADDR_PRESET, 32'd5);
        applyStimulus(ADDR_CTRL, 32'h9);
        d = expiryDelay(5);
        runIrqWindow("oneShot5", 5, 1'b0, 1'b1, d + 3, pulses);
        checkReg("oneShotCtrl", ADDR_CTRL, 32'h18);
        checkReg("oneShotCount", ADDR_COUNT, 32'h0);
        waitEdges(3);
        checkOutput("oneShotHeld", {31'd0, irq}, 32'd1);
        applyStimulus(ADDR_CTRL, 32'h0);
        checkOutput("ackIrq", {31'd0, irq}, 32'd0);
        checkReg("ackCtrl", ADDR_CTRL, 32'h0);

        // Auto-reload, PRESET=3: five consecutive pulses
        applyStimulus(ADDR_PRESET, 32'd3);
        applyStimulus(ADDR_CTRL, 32'hB);
        d = expiryDelay(3);
        runIrqWindow("auto3", 3, 1'b1, 1'b1, d + 4 * d, pulses);
        checkOutput("auto3Pulses", pulses, 32'd5);
        stopTimer("auto3Stop");

        // PRESET=0 behaves as PRESET=1
        applyStimulus(ADDR_PRESET, 32'd0);
        applyStimulus(ADDR_CTRL, 32'h9);
        runIrqWindow("preset0", 0, 1'b0, 1'b1, expiryDelay(1) + 2, pulses);
        stopTimer("preset0Stop");

        // Disable mid-count: COUNT holds, no irq
        applyStimulus(ADDR_PRESET, 32'd10);
        applyStimulus(ADDR_CTRL, 32'h9);
        waitEdges(2);
        checkReg("loadedCount", ADDR_COUNT, 32'd10);
        waitEdges(2);
        applyStimulus(ADDR_CTRL, 32'h0);
        hold = 10 - (5 - 2) / PS;
        for (int k = 0; k < 15; k++) begin
            waitEdges(1);
            checkOutput("disableIrq", {31'd0, irq}, 32'd0);
        end
        checkReg("holdCount", ADDR_COUNT, hold);
        checkReg("holdCtrl", ADDR_CTRL, 32'h0);

        // IM=0: pending set but irq masked
        applyStimulus(ADDR_PRESET, 32'd2);
        applyStimulus(ADDR_CTRL, 32'h1);
        runIrqWindow("masked", 2, 1'b0, 1'b0, expiryDelay(2) + 2, pulses);
        checkReg("maskedCtrl", ADDR_CTRL, 32'h10);
        stopTimer("maskedStop");

        // CTRL write on the expiry edge clears pending and keeps written EN
        applyStimulus(ADDR_PRESET, 32'd4);
        applyStimulus(ADDR_CTRL, 32'h9);
        d = expiryDelay(4);
        runIrqWindow("raceA", 4, 1'b0, 1'b1, d - 1, pulses);
        applyStimulus(ADDR_CTRL, 32'h9);
        checkReg("raceACtrl", ADDR_CTRL, 32'h9);
        checkOutput("raceAIrq", {31'd0, irq}, 32'd0);
        waitEdges(3);
        checkOutput("raceAQuiet", {31'd0, irq}, 32'd0);
        stopTimer("raceAStop");

        // CTRL write on the INT edge beats the one-shot EN clear and restarts
        applyStimulus(ADDR_CTRL, 32'h9);
        runIrqWindow("raceB", 4, 1'b0, 1'b1, d, pulses);
        applyStimulus(ADDR_CTRL, 32'h9);
        checkReg("raceBCtrl", ADDR_CTRL, 32'h9);
        runIrqWindow("raceBRestart", 4, 1'b0, 1'b1, d + 2, pulses);
        checkReg("raceBDone", ADDR_CTRL, 32'h18);
        stopTimer("raceBStop");

        // Randomized preset/mode/mask combinations
        for (int it = 0; it < 6; it++) begin
            p     = $urandom_range(0, 6);
            md    = 2'($urandom_range(0, 3));
            imBit = 1'($urandom_range(0, 1));
            applyStimulus(ADDR_PRESET, p);
            applyStimulus(ADDR_CTRL, {28'd0, imBit, md, 1'b1});
            d = expiryDelay(p);
            runIrqWindow("random", p, md == MODE_AUTO, imBit, 3 * d + 1, pulses);
            stopTimer("randomStop");
        end

        // Reset in the middle of a count
        applyStimulus(ADDR_PRESET, 32'd10);
        applyStimulus(ADDR_CTRL, 32'hB);
        waitEdges(4);
        pulseReset();
        checkReg("midRstCtrl", ADDR_CTRL, 32'h0);
        checkReg("midRstPreset", ADDR_PRESET, 32'h0);
        checkReg("midRstCount", ADDR_COUNT, 32'h0);
        checkOutput("midRstIrq", {31'd0, irq}, 32'd0);
        waitEdges(5);
        checkReg("midRstIdle", ADDR_COUNT, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_timer.md
Name: mips_timer

Overview:
- Memory-mapped programmable countdown timer; bus slave on the CPU data bus.
- Generates a level interrupt request that feeds one bit of the coprocessor-0 external interrupt inputs, i.e. it is the interrupt source for CP0's interrupt receiver.
- Software programs a preset and a mode. The timer counts down and raises IRQ on expiry, either once (one-shot) or periodically (auto-reload).

Parameters:
- PRESCALE_LOG2, 4, with TIMER_PRESCALE_EN defined: count decrements once every 2^PRESCALE_LOG2 cycles; ignored otherwise.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- addr  in  2  word select (byte address bits [3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
- we  in  1  write strobe, sampled at posedge clk
- wdata  in  32  write data
- rdata  out  32  combinational read of the register selected by addr
- irq  out  1  interrupt request; equals CTRL.IM AND pending

Behaviour:
- CTRL register layout:
  - [0] EN
  - [2:1] MODE: 0=one-shot, 1=auto-reload, 2/3 treated as one-shot
  - [3] IM
  - [4] PEND (read-only)
  - other bits read 0
- PRESET: 32-bit read/write.
- COUNT: 32-bit, read-only; writes are ignored.
- Address 3 reads 0; writes to it are ignored.
- Reset: CTRL=0, PRESET=0, COUNT=0, pending=0, state=IDLE, irq=0.
- FSM states IDLE, LOAD, CNT, INT; each transition takes one clock edge.
  - IDLE: EN=1 -> LOAD.
  - LOAD: COUNT<=PRESET; -> CNT.
  - CNT:
    - EN=0 -> IDLE; COUNT holds its value.
    - COUNT>1: COUNT<=COUNT-1.
    - COUNT<=1: COUNT<=0, pending<=1, -> INT.
  - INT, MODE=1: -> LOAD; pending<=0 (one-cycle irq pulse).
  - INT, other modes: -> IDLE; EN<=0; pending stays 1 until any CTRL write or reset.
- Latency:
  - EN written at edge E0: LOAD at E1, COUNT=PRESET after E2.
  - pending/irq rise after edge E(max(PRESET,1)+2).
  - Auto-reload period: PRESET+2 cycles (minimum 3 when PRESET<=1).
- PRESET=0 behaves exactly as PRESET=1.
- Simultaneous events:
  - Software CTRL write wins over the hardware EN clear in the same cycle; the written EN value is kept.
  - A CTRL write in the same cycle the FSM sets pending clears pending, so the software write wins.
  - A PRESET write during CNT does not disturb COUNT; it takes effect at the next LOAD.
  - Clearing EN in any non-IDLE state forces the FSM to IDLE on the next edge. The exception is LOAD, which completes its load first.
- irq is derived from registered state only and has no combinational path from wdata.
- Reset mid-count returns every register to its reset value on the next edge.

Optional Feature:
- Macro TIMER_PRESCALE_EN.
- Defined:
  - A PRESCALE_LOG2-bit prescaler counter is cleared in LOAD.
  - In CNT, COUNT decrements (and the expiry check is made) only in cycles where the prescaler is all ones.
  - Period becomes (max(PRESET,1) * 2^PRESCALE_LOG2) + 2 cycles.
- Undefined: COUNT decrements every cycle; PRESCALE_LOG2 has no effect.

Decomposition:
- Shared package holds:
  - register word offsets (CTRL=0, PRESET=1, COUNT=2)
  - CTRL bit indices (EN, MODE, IM, PEND)
  - MODE encodings
  - FSM state encoding (2 bits)
- One natural sub-module, timer_prescaler (counter plus tick output), instantiated only when TIMER_PRESCALE_EN is defined.

Test Plan:
- Reset, then read all addresses -> rdata=0, irq=0; writing COUNT=0x1234 leaves the COUNT read at 0.
- PRESET=5, then CTRL=0x9 (EN, one-shot, IM) at edge E0 -> irq rises after E7; CTRL reads 0x18 (EN cleared, PEND set); irq stays high until a CTRL write of 0x0, after which irq=0 on the next cycle.
- PRESET=3, CTRL=0xB (auto-reload, IM) -> irq is a one-cycle pulse every 5 cycles; five consecutive pulses are checked.
- PRESET=0 in one-shot mode -> irq after E3, identical to PRESET=1.
- Count running with COUNT=10, write CTRL=0x0 -> FSM reaches IDLE, COUNT holds its value, no irq. Separately, IM=0 with expiry -> PEND=1 but irq=0.
- CTRL write issued in the same cycle as expiry in one-shot mode -> the written EN value is kept and PEND=0. With TIMER_PRESCALE_EN and PRESCALE_LOG2=2, PRESET=2 -> one-shot irq after E(2*4+2)=E10.
